// File: rtl/audio_pwm_pkg.sv
// ============================================================================
// Module   : audio_pwm_pkg
// Brief    : Shared defaults, the sample-to-duty shift and the duty type for
//            the audio-to-PWM converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pwm_pkg;

  // Default audio sample width (signed two's complement)
  localparam int unsigned c_SAMPLE_W   = 16;
  // Default PWM counter width; the period is 2^c_CNT_W clocks
  localparam int unsigned c_CNT_W      = 7;
  // Right shift that maps a full-scale magnitude onto 0..2^c_CNT_W
  localparam int unsigned c_DUTY_SHIFT = c_SAMPLE_W - 1 - c_CNT_W;

  // Duty needs one bit more than the counter so that full scale (2^CNT_W)
  // can mean "high for the whole period"
  typedef logic [c_CNT_W:0] duty_t;

endpackage

`default_nettype wire

// File: rtl/audio_to_pwm_conversion_pwm_counter.sv
// ============================================================================
// Module   : pwm_counter
// Brief    : Free-running PWM period counter with wrap flag and left-aligned
//            compare against the latched duty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_counter #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W:0]   duty_i,
  output logic             wrap_o,
  output logic             led_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             led_q;
  logic             led_d;

  // Next-state: counter wraps naturally at 2^CNT_W; output high while cnt < duty
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    wrap_o = &cnt_q;
    led_d  = ({1'b0, cnt_q} < duty_i);
  end

  // Counter and registered PWM output, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

`default_nettype wire

// File: rtl/audio_to_pwm_conversion.sv
// ============================================================================
// Module   : audio_to_pwm_conversion
// Brief    : Converts a signed audio sample into a left-aligned PWM output
//            whose duty equals the normalised sample magnitude. The duty is
//            latched once per period so the waveform never glitches.
// Options  : APWM_INPUT_REG_EN - register the sample before the magnitude
//            computation (one extra clock of latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_to_pwm_conversion
  import audio_pwm_pkg::*;
#(
  parameter int unsigned SAMPLE_W = c_SAMPLE_W,
  parameter int unsigned CNT_W    = c_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                led_out
);

  localparam int unsigned c_SHIFT = SAMPLE_W - 1 - CNT_W;

  logic [SAMPLE_W-1:0] sample_src;
  logic [SAMPLE_W-1:0] mag;
  logic [CNT_W:0]      duty_d;
  logic [CNT_W:0]      duty_q;
  logic                wrap;

`ifdef APWM_INPUT_REG_EN
  logic [SAMPLE_W-1:0] sample_q;

  // Optional input stage: retime the sample before the magnitude path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample;
    end
  end

  assign sample_src = sample_q;
`else
  assign sample_src = sample;
`endif

  // Magnitude as unsigned SAMPLE_W bits (most-negative value maps to 2^(W-1)),
  // then scale down so full scale lands exactly on 2^CNT_W
  always_comb begin
    mag    = sample_src[SAMPLE_W-1] ? ('0 - sample_src) : sample_src;
    duty_d = (CNT_W+1)'(mag >> c_SHIFT);
  end

  // Duty is only taken at the last clock of a period so it applies cleanly
  // from the next period onward
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q <= '0;
    end else if (wrap) begin
      duty_q <= duty_d;
    end
  end

  pwm_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .duty_i (duty_q),
    .wrap_o (wrap),
    .led_o  (led_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_audio_to_pwm_conversion.sv
// ============================================================================
// Module   : tb_audio_to_pwm_conversion
// Brief    : Self-checking bench for audio_to_pwm_conversion with a
//            period-level reference model. Honours APWM_INPUT_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_to_pwm_conversion;

  localparam int SW  = 16;
  localparam int CW  = 7;
  localparam int PER = 1 << CW;

  logic          clk    = 1'b0;
  logic          reset  = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          led_out;

  int total = 0;
  int bad   = 0;

  // Reference model state: edges since reset release, duty of current period,
  // and the sample seen at the previous edge (for the registered-input build)
  int          k           = 0;
  int          duty_cur    = 0;
  logic [SW-1:0] prev_sample = '0;

  always #5 clk = ~clk;

  audio_to_pwm_conversion #(
    .SAMPLE_W (SW),
    .CNT_W    (CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sample  (sample),
    .led_out (led_out)
  );

  // Duty from plain arithmetic: |sample| scaled so that 2^(SW-1) -> 2^CW
  function automatic int ref_duty(input logic [SW-1:0] s);
    int v;
    int m;
    v = $signed(s);
    m = (v < 0) ? -v : v;
    return m / (1 << (SW - 1 - CW));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, then check just after it
  task automatic tick();
    int            exp_led;
    int            exp_cnt;
    int            cpre;
    logic [SW-1:0] captured;
    @(posedge clk);
    if (!reset) begin
      exp_led = 0;
      exp_cnt = 0;
    end else begin
`ifdef APWM_INPUT_REG_EN
      captured = prev_sample;
`else
      captured = sample;
`endif
      cpre    = k % PER;
      exp_led = (cpre < duty_cur) ? 1 : 0;
      if (cpre == PER - 1) duty_cur = ref_duty(captured);
      prev_sample = sample;
      k++;
      exp_cnt = k % PER;
    end
    #1;
    check_eq("led", led_out, exp_led);
    check_eq("cnt", dut.u_counter.cnt_q, exp_cnt);
  endtask

  task automatic run_period(output int highs);
    highs = 0;
    repeat (PER) begin
      tick();
      highs += int'(led_out);
    end
  endtask

  task automatic align();
    while (reset && (k % PER) != 0) tick();
  endtask

  // Asynchronous reset pulse: output must drop without waiting for an edge
  task automatic reset_pulse(input int hold);
    reset = 1'b0;
    #1;
    check_eq("rst_led_async", led_out, 0);
    k           = 0;
    duty_cur    = 0;
    prev_sample = '0;
    repeat (hold) tick();
    reset = 1'b1;
  endtask

  logic [SW-1:0] tv [7] = '{16'hC000, 16'h8000, 16'h0000, 16'h7FFF, 16'h00FF, 16'hFF01, 16'h4000};
  int            te [7] = '{64, 128, 0, 127, 0, 0, 64};

  initial begin
    int h;
    // Reset held low with clock running
    reset = 1'b0;
    repeat (5) tick();
    check_eq("rst_led", led_out, 0);
    reset = 1'b1;

    // 0x4000 from release: first period low, then 64/128
    sample = 16'h4000;
    run_period(h); check_eq("p0_4000", h, 0);
    run_period(h); check_eq("p1_4000", h, 64);
    run_period(h); check_eq("p2_4000", h, 64);

    // Duty table including the extremes
    for (int i = 0; i < 7; i++) begin
      align();
      sample = tv[i];
      run_period(h);
      run_period(h);
      check_eq($sformatf("duty_%h", tv[i]), h, te[i]);
    end

    // Mid-period change only takes effect at the next period
    align();
    h = 0;
    repeat (PER) begin
      tick();
      h += int'(led_out);
      if (((k - 1) % PER) == 40) sample = 16'h2000;
    end
    check_eq("mid_keep", h, 64);
    run_period(h); check_eq("mid_next", h, 32);

    // Reset at cnt = 30 with duty 64
    sample = 16'h4000;
    align();
    run_period(h);
    repeat (30) tick();
    check_eq("pre_rst_led", led_out, 1);
    reset_pulse(3);
    run_period(h); check_eq("post_rst_p0", h, 0);
    run_period(h); check_eq("post_rst_p1", h, 64);

    // Randomised stimulus against the model
    repeat (4000) begin
      tick();
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 0) sample = tv[$urandom_range(0, 6)];
        else                           sample = SW'($urandom);
      end
      if ($urandom_range(0, 1499) == 0) reset_pulse($urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
